reg_serial_tx: RTL and testbench
================================

// Module: reg_serial_tx
// PURPOSE
//  Parallel-to-serial transmitter. Drains an N-bit register word (e.g. n_bit_register output) onto a 1-bit link.
//  Accepts one word via valid/ready, shifts it out MSB-first, one bit per clk, with a frame strobe.
//  Sits between datapath registers and the serial receiver/deserializer at the far end of the link.
// PARAMETERS
//  N        16   data word width in bits; legal range N >= 2
//  CNT_W    $clog2(N+1)   bit-counter width; derived, not overridden
// PORTS
//  clk        in   1   rising-edge clock, single clock domain
//  reset      in   1   synchronous, active-low reset; sampled on posedge clk
//  in_data    in   N   word to transmit; sampled only on accept
//  in_valid   in   1   upstream holds in_data stable while high
//  in_ready   out  1   high only in IDLE; accept = in_valid & in_ready at posedge
//  ser_out    out  1   serial data, registered
//  ser_frame  out  1   high on every cycle ser_out carries a valid bit
//  busy       out  1   high in SHIFT (and PAR); equals ~in_ready
//  done       out  1   one-cycle pulse on the first IDLE cycle after the final bit
// BEHAVIOUR
//  Reset (reset=0 at posedge):
//   - state=IDLE, shift reg=0, count=0, ser_out=0, ser_frame=0, done=0, busy=0.
//   - in_ready=1 from the first cycle after the reset edge.
//   - in_valid is ignored while reset=0.
//  States:
//   - IDLE -> SHIFT on accept: load in_data, count=N-1.
//   - SHIFT: drive sreg[N-1], shift left; count-- each cycle.
//   - Last bit (count==0): -> IDLE, or -> PAR when PARITY_EN is defined.
//   - PAR -> IDLE after one cycle.
//  Latency:
//   - Accept at edge k -> bit N-1 on ser_out during cycle k+1; bit 0 during cycle k+N.
//   - done=1 during cycle k+N+1, with ser_frame=0 and in_ready=1 in that cycle.
//  Frame period and back-to-back:
//   - Minimum frame period N+1 cycles (N+2 with parity).
//   - A word accepted in the done cycle starts its frame the next cycle: exactly one idle gap between frames.
//  Boundary conditions:
//   - in_valid while busy: ignored, nothing latched; in_data changes mid-frame do not affect the frame.
//   - Reset asserted mid-frame: frame aborted, ser_frame=0 next cycle, no done pulse, word discarded.
//   - ser_out is held at its last value when ser_frame=0; consumers must qualify with ser_frame.
//   - Counter never wraps: the count==0 check precedes the decrement.
// CONFIGURATION
//  PARITY_EN defined:
//   - After bit 0, one extra cycle in state PAR.
//   - ser_out = even parity (^word), ser_frame=1, busy=1.
//   - done moves one cycle later.
//  PARITY_EN undefined:
//   - PAR state and parity logic absent; frame is exactly N bits.
//  Port list is identical in both builds.
// STRUCTURE
//  Shared package/include holds:
//   - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_PAR=2'd2.
//   - default word width constant WORD_W=16, used by both tx and rx.
//  One sub-module: piso_shift_reg #(N):
//   - ports: clk, reset, load, shift, d, msb.
//   - holds the data word; the FSM, counter and parity stay in reg_serial_tx.
// TESTING (N=16 unless stated)
//  1. Reset low 3 cycles with in_valid=1, in_data=16'hFFFF
//     -> ser_frame=0, done=0 throughout; in_ready=1 after release; no frame sent.
//  2. Send 16'hA5C3
//     -> ser_out=1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 on cycles k+1..k+16; ser_frame high 16 cycles; done at k+17.
//  3. in_valid held with 16'hFFFF then 16'h0001
//     -> second word accepted in the done cycle; exactly 1 idle cycle between frames; bits exact.
//  4. 1-cycle in_valid pulse with 16'h1234 at bit 5 of a frame
//     -> ignored; current frame bits unchanged; no second frame.
//  5. reset=0 for one cycle at bit 7 of 16'hFFFF
//     -> ser_frame=0 next cycle, no done; following 16'h8000 sends 1 then fifteen 0s.
//  6. PARITY_EN: 16'h0007 -> 17th bit=1; 16'h0003 -> 17th bit=0; done at k+18 in both.

Source files
------------

// File: rtl/reg_serial_tx_pkg.sv
// Shared definitions for the serial link transmitter and its receiver.
// State encodings and the default word width live here.
package reg_serial_tx_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_PAR   = 2'd2
   } state_t;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out word register; msb is the next bit to send.
module piso_shift_reg
   import reg_serial_tx_pkg::*;
#(
   parameter int N = WORD_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         shift,
   input  logic [N-1:0] d,
   output logic         msb
);

   logic [N-1:0] q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (shift) begin
         q <= {q[N-2:0], 1'b0};
      end
   end

   assign msb = q[N-1];

endmodule

// File: rtl/reg_serial_tx.sv
// MSB-first parallel-to-serial transmitter with valid/ready intake.
// Define PARITY_EN to append an even-parity bit to every frame.
module reg_serial_tx
   import reg_serial_tx_pkg::*;
#(
   parameter  int N     = WORD_W,
   localparam int CNT_W = $clog2(N + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         ser_out,
   output logic         ser_frame,
   output logic         busy,
   output logic         done
);

   state_t           state;
   logic [CNT_W-1:0] count;
   logic             load;
   logic             shift;
   logic             msb;

   assign in_ready = (state == ST_IDLE);
   assign busy     = ~in_ready;
   assign load     = in_valid & in_ready;
   assign shift    = (state == ST_SHIFT) && (count != '0);

   // The register is loaded pre-shifted: bit N-1 goes straight to ser_out.
   piso_shift_reg #(.N(N)) u_sreg (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .shift (shift),
      .d     ({in_data[N-2:0], 1'b0}),
      .msb   (msb)
   );

`ifdef PARITY_EN
   logic par;

   always_ff @(posedge clk) begin
      if (!reset) begin
         par <= 1'b0;
      end else if (load) begin
         par <= ^in_data;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         count     <= '0;
         ser_out   <= 1'b0;
         ser_frame <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  state     <= ST_SHIFT;
                  count     <= CNT_W'(N - 1);
                  ser_out   <= in_data[N-1];
                  ser_frame <= 1'b1;
               end
            end
            ST_SHIFT: begin
               // Test for zero before decrementing so count never wraps.
               if (count == '0) begin
`ifdef PARITY_EN
                  state   <= ST_PAR;
                  ser_out <= par;
`else
                  state     <= ST_IDLE;
                  ser_frame <= 1'b0;
                  done      <= 1'b1;
`endif
               end else begin
                  count   <= count - 1'b1;
                  ser_out <= msb;
               end
            end
`ifdef PARITY_EN
            ST_PAR: begin
               state     <= ST_IDLE;
               ser_frame <= 1'b0;
               done      <= 1'b1;
            end
`endif
            default: begin
               state     <= ST_IDLE;
               ser_frame <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_serial_tx.sv
// Randomized bench for reg_serial_tx against a timeline model of
// expected per-cycle link activity.
module tb_reg_serial_tx;

   localparam int N   = 16;
   localparam int MAX = 4096;
`ifdef PARITY_EN
   localparam int L = N + 1;
`else
   localparam int L = N;
`endif

   logic         clk;
   logic         reset;
   logic [N-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic         ser_out;
   logic         ser_frame;
   logic         busy;
   logic         done;

   reg_serial_tx #(.N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ser_out   (ser_out),
      .ser_frame (ser_frame),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected activity indexed by cycle t (the cycle after posedge t).
   bit e_frame [MAX];
   bit e_bit   [MAX];
   bit e_done  [MAX];
   bit e_ready [MAX];
   bit rst_at  [MAX];

   int checks;
   int failures;
   int t;
   bit held;
   bit acc;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%b want=%b", tag, t, obs, exp);
      end
   endtask

   task automatic check_cycle();
      if (t >= 1) begin
         if (rst_at[t]) held = 1'b0;
         if (e_frame[t]) held = e_bit[t];
         chk("ser_frame", ser_frame, e_frame[t]);
         chk("done", done, e_done[t]);
         chk("in_ready", in_ready, e_ready[t]);
         chk("busy", busy, ~e_ready[t]);
         chk("ser_out", ser_out, held);
      end
   endtask

   // Apply the link rules for posedge e given the inputs seen there.
   task automatic model_edge(input int e, input bit r, input bit v,
                             input logic [N-1:0] d);
      acc = 1'b0;
      if (!r) begin
         rst_at[e] = 1'b1;
         for (int k = e; k < e + N + 4; k++) begin
            e_frame[k] = 1'b0;
            e_done[k]  = 1'b0;
            e_ready[k] = 1'b1;
         end
      end else if (v && e_ready[e-1]) begin
         acc = 1'b1;
         for (int i = 0; i < N; i++) begin
            e_frame[e+i] = 1'b1;
            e_bit[e+i]   = d[N-1-i];
         end
`ifdef PARITY_EN
         e_frame[e+N] = 1'b1;
         e_bit[e+N]   = ^d;
`endif
         for (int i = 0; i < L; i++) e_ready[e+i] = 1'b0;
         e_done[e+L] = 1'b1;
      end
   endtask

   task automatic tick(input bit r, input bit v, input logic [N-1:0] d);
      @(negedge clk);
      check_cycle();
      reset    = r;
      in_valid = v;
      in_data  = d;
      model_edge(t + 1, r, v, d);
      @(posedge clk);
      t++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b0, N'($urandom));
   endtask

   task automatic send_held(input logic [N-1:0] d);
      int guard;
      guard = 0;
      do begin
         tick(1'b1, 1'b1, d);
         guard++;
      end while (!acc && guard < 3 * L);
      if (!acc) begin
         failures++;
         $display("FAIL accept_timeout cycle=%0d got=none want=accept", t);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      t        = 0;
      held     = 1'b0;
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      for (int k = 0; k < MAX; k++) begin
         e_frame[k] = 1'b0;
         e_bit[k]   = 1'b0;
         e_done[k]  = 1'b0;
         e_ready[k] = 1'b1;
         rst_at[k]  = 1'b0;
      end

      // Reset with a pending word that must not be taken.
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 16'hFFFF);
      tick(1'b1, 1'b0, 16'hFFFF);
      idle(3);

      // Single known pattern.
      send_held(16'hA5C3);
      idle(L + 3);

      // Back-to-back with valid held high.
      send_held(16'hFFFF);
      send_held(16'h0001);
      idle(L + 3);

      // Stray valid pulse while the link is busy.
      send_held(16'hA5A5);
      idle(4);
      tick(1'b1, 1'b1, 16'h1234);
      idle(L + 3);

      // Mid-frame reset, then a fresh word.
      send_held(16'hFFFF);
      idle(6);
      tick(1'b0, 1'b0, 16'hFFFF);
      send_held(16'h8000);
      idle(L + 3);

      // Parity corner words.
      send_held(16'h0007);
      idle(L + 2);
      send_held(16'h0003);
      idle(L + 2);

      // Random traffic with occasional resets and data churn.
      for (int i = 0; i < 1500; i++) begin
         tick(($urandom % 150) != 0, ($urandom % 3) != 0, N'($urandom));
      end
      idle(L + 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
